// File: rtl/uart_tx_sched.sv
// uart_tx_sched: transmit-side scheduler for the UART peripheral.
// Two requesters each own a one-word holding buffer. Full buffers are served
// round-robin: the chosen word is presented to the transmitter with a one-state
// txStart pulse, and frame progress is then tracked by counting sTick so that a
// new frame never starts before the transmitter is back in idle.
//
// Handshake contract: a requester raises reqN with dinN and holds both until
// the first rising edge on which reqN && rdyN; that edge moves dinN into
// bufN. The transmitter side is a Moore request: txStart stays high for the
// whole LAUNCH state, and txDoneTick high in that state means the word was
// taken on that edge.
module uart_tx_sched #(
  parameter int dataBits = 8,
  parameter int sbTick   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sTick,
  input  logic                req0,
  input  logic [dataBits-1:0] din0,
  output logic                rdy0,
  input  logic                req1,
  input  logic [dataBits-1:0] din1,
  output logic                rdy1,
  output logic                txStart,
  output logic [dataBits-1:0] txDin,
  input  logic                txDoneTick,
  output logic                busy,
  output logic                owner,
  output logic                full0,
  output logic                full1,
  output logic [1:0]          fsm_state
);

  // One frame as seen by the transmitter: start + data bits at 16 ticks each,
  // plus the stop-bit ticks.
  localparam int frameTicks = 16 * (dataBits + 1) + sbTick;
  localparam int cntW       = $clog2(frameTicks);
  localparam logic [cntW-1:0] cntLast = cntW'(frameTicks - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_FRAME  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [dataBits-1:0] buf0;
  logic [dataBits-1:0] buf1;
  logic [cntW-1:0]     cnt;
  logic                last;
  logic                rdy_en;
  logic                sel;
  logic                any_full;
  logic                take0;
  logic                take1;
  logic                accept;
  logic                frame_end;

  // Buffer readiness is held low during reset and for the release edge itself.
  assign rdy0 = rdy_en && !full0;
  assign rdy1 = rdy_en && !full1;

  assign take0     = req0 && rdy0;
  assign take1     = req1 && rdy1;
  assign any_full  = full0 || full1;
  assign accept    = (state == ST_LAUNCH) && txDoneTick;
  assign frame_end = (state == ST_FRAME) && sTick && (cnt == cntLast);

  // Arbitration: a lone full buffer wins; on a tie the requester not served last wins.
  always_comb begin
    sel = 1'b0;
    if (full0 && full1) begin
      sel = !last;
    end else if (full1) begin
      sel = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: IDLE -> LAUNCH on any full buffer, LAUNCH -> FRAME on accept,
  // FRAME -> IDLE on the last frame tick.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (any_full) begin
          state_next = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        if (txDoneTick) begin
          state_next = ST_FRAME;
        end
      end
      ST_FRAME: begin
        if (sTick && (cnt == cntLast)) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Moore outputs decoded from the state.
  always_comb begin
    txStart   = 1'b0;
    busy      = 1'b0;
    fsm_state = state;
    case (state)
      ST_IDLE: begin
        txStart = 1'b0;
        busy    = 1'b0;
      end
      ST_LAUNCH: begin
        txStart = 1'b1;
        busy    = 1'b1;
      end
      ST_FRAME: begin
        txStart = 1'b0;
        busy    = 1'b1;
      end
      default: begin
        txStart = 1'b0;
        busy    = 1'b0;
      end
    endcase
  end

  // Ready enable: rises on the first clock edge after reset is released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
    end
  end

  // Buffer 0: capture on transfer, free only once the transmitter took its word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf0  <= '0;
      full0 <= 1'b0;
    end else begin
      if (take0) begin
        buf0  <= din0;
        full0 <= 1'b1;
      end else if (accept && (owner == 1'b0)) begin
        full0 <= 1'b0;
      end
    end
  end

  // Buffer 1: capture on transfer, free only once the transmitter took its word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf1  <= '0;
      full1 <= 1'b0;
    end else begin
      if (take1) begin
        buf1  <= din1;
        full1 <= 1'b1;
      end else if (accept && (owner == 1'b1)) begin
        full1 <= 1'b0;
      end
    end
  end

  // Launch registers: txDin and owner change only on the IDLE-to-LAUNCH edge,
  // so txDin is stable for the whole transmitter start state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      txDin <= '0;
      owner <= 1'b0;
    end else if ((state == ST_IDLE) && any_full) begin
      txDin <= sel ? buf1 : buf0;
      owner <= sel;
    end
  end

  // Round-robin history: remember who was served once the transmitter accepts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last <= 1'b1;
    end else if (accept) begin
      last <= owner;
    end
  end

  // Frame tick counter: cleared at accept, advanced by sTick in FRAME only,
  // and held at its terminal value on the last tick so it never wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if ((state == ST_FRAME) && sTick && !frame_end) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: reset state, tie after reset, single word
// with refill during flight, backpressure with a slow transmitter accept,
// round-robin fairness and reset in the middle of a frame.
module tb_uart_tx_sched;

  logic       clk       = 1'b0;
  logic       reset     = 1'b0;
  logic       s_tick    = 1'b1;
  logic       req0      = 1'b0;
  logic       req1      = 1'b0;
  logic [7:0] din0      = 8'h00;
  logic [7:0] din1      = 8'h00;
  logic       tx_accept = 1'b1;

  logic       rdy0;
  logic       rdy1;
  logic       tx_start;
  logic [7:0] tx_din;
  logic       tx_done_tick;
  logic       busy;
  logic       owner;
  logic       full0;
  logic       full1;
  logic [1:0] fsm_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_launch = 0;

  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  int         lc_q[$];

  // Idle transmitter model: takes the word in the same cycle txStart is seen.
  assign tx_done_tick = tx_start & tx_accept;

  uart_tx_sched #(.dataBits(8), .sbTick(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .sTick      (s_tick),
    .req0       (req0),
    .din0       (din0),
    .rdy0       (rdy0),
    .req1       (req1),
    .din1       (din1),
    .rdy1       (rdy1),
    .txStart    (tx_start),
    .txDin      (tx_din),
    .txDoneTick (tx_done_tick),
    .busy       (busy),
    .owner      (owner),
    .full0      (full0),
    .full1      (full1),
    .fsm_state  (fsm_state)
  );

  // Clock generation.
  always #5 clk = ~clk;

  // Launch monitor: records every word the transmitter accepts.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_start && tx_done_tick) begin
      got_q.push_back({owner, tx_din});
      lc_q.push_back(cyc);
      n_launch <= n_launch + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts cycles until busy falls, bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 400) begin
      tick();
      n++;
    end
  endtask

  // Scoreboard: compares accepted words against the expected queue, in order.
  task automatic check_launches(input string tag);
    logic [8:0] g;
    logic [8:0] e;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_word"}, g, e);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int n;
    int guard;
    int base;

    // ---- reset state ----
    reset = 1'b0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_txstart", tx_start, 0);
    chk("rst_full0", full0, 0);
    chk("rst_full1", full1, 0);
    chk("rst_rdy0", rdy0, 0);
    chk("rst_rdy1", rdy1, 0);
    chk("rst_owner", owner, 0);
    chk("rst_txdin", tx_din, 0);
    chk("rst_state", fsm_state, 0);
    reset = 1'b1;
    chk("rel_rdy0_low", rdy0, 0);
    tick();
    chk("rel_rdy0", rdy0, 1);
    chk("rel_rdy1", rdy1, 1);

    // ---- tie after reset: requester 0 first ----
    req0 = 1'b1; din0 = 8'h11;
    req1 = 1'b1; din1 = 8'h22;
    tick();
    req0 = 1'b0; req1 = 1'b0;
    chk("tie_full0", full0, 1);
    chk("tie_full1", full1, 1);
    chk("tie_busy0", busy, 0);
    tick();
    chk("tie_start1", tx_start, 1);
    chk("tie_din1", tx_din, 8'h11);
    chk("tie_owner1", owner, 0);
    tick();
    chk("tie_start1_off", tx_start, 0);
    chk("tie_full0_clr", full0, 0);
    chk("tie_full1_hold", full1, 1);
    chk("tie_state_frame", fsm_state, 2);
    wait_idle(n);
    chk("tie_frame1_len", n, 160);
    chk("tie_gap_start", tx_start, 0);
    tick();
    chk("tie_start2", tx_start, 1);
    chk("tie_din2", tx_din, 8'h22);
    chk("tie_owner2", owner, 1);
    tick();
    chk("tie_full1_clr", full1, 0);
    wait_idle(n);
    chk("tie_frame2_len", n, 160);
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b1, 8'h22});
    check_launches("tie");

    // ---- single word, then refill while it is in flight ----
    req0 = 1'b1; din0 = 8'hA5;
    tick();
    req0 = 1'b0;
    chk("one_full0", full0, 1);
    chk("one_rdy0", rdy0, 0);
    chk("one_nostart", tx_start, 0);
    tick();
    chk("one_start", tx_start, 1);
    chk("one_din", tx_din, 8'hA5);
    chk("one_owner", owner, 0);
    req0 = 1'b1; din0 = 8'h33;
    tick();
    chk("refill_blocked", full0, 0);
    chk("one_start_off", tx_start, 0);
    chk("one_busy", busy, 1);
    tick();
    chk("refill_captured", full0, 1);
    req0 = 1'b0;
    chk("refill_txdin_hold", tx_din, 8'hA5);
    n = 1;
    while (busy && n < 400) begin
      tick();
      n++;
    end
    chk("one_frame_len", n, 160);
    chk("refill_txdin_end", tx_din, 8'hA5);
    chk("refill_idle_start", tx_start, 0);
    tick();
    chk("refill_start", tx_start, 1);
    chk("refill_din", tx_din, 8'h33);
    tick();
    wait_idle(n);
    chk("refill_frame_len", n, 160);
    exp_q.push_back({1'b0, 8'hA5});
    exp_q.push_back({1'b0, 8'h33});
    check_launches("refill");

    // ---- slow accept, then backpressure on requester 1 ----
    tx_accept = 1'b0;
    req0 = 1'b1; din0 = 8'h77;
    tick();
    req0 = 1'b0;
    tick();
    chk("slow_start", tx_start, 1);
    chk("slow_din", tx_din, 8'h77);
    repeat (3) tick();
    chk("slow_start_held", tx_start, 1);
    chk("slow_full0_held", full0, 1);
    chk("slow_state", fsm_state, 1);
    tx_accept = 1'b1;
    tick();
    chk("slow_frame", fsm_state, 2);
    chk("slow_full0_clr", full0, 0);
    req1 = 1'b1; din1 = 8'h55;
    tick();
    chk("bp_full1", full1, 1);
    din1 = 8'h66;
    repeat (20) tick();
    chk("bp_rdy1", rdy1, 0);
    chk("bp_full1_held", full1, 1);
    wait_idle(n);
    tick();
    chk("bp_start", tx_start, 1);
    chk("bp_din_orig", tx_din, 8'h55);
    chk("bp_owner", owner, 1);
    tick();
    chk("bp_full1_clr", full1, 0);
    tick();
    chk("bp_recapture", full1, 1);
    req1 = 1'b0;
    wait_idle(n);
    tick();
    chk("bp_din2", tx_din, 8'h66);
    chk("bp_owner2", owner, 1);
    tick();
    wait_idle(n);
    exp_q.push_back({1'b0, 8'h77});
    exp_q.push_back({1'b1, 8'h55});
    exp_q.push_back({1'b1, 8'h66});
    check_launches("bp");

    // ---- round-robin with both buffers kept full ----
    lc_q.delete();
    base = n_launch;
    req0 = 1'b1; din0 = 8'h40;
    req1 = 1'b1; din1 = 8'h41;
    guard = 0;
    while (n_launch < base + 6 && guard < 3000) begin
      tick();
      guard++;
    end
    req0 = 1'b0; req1 = 1'b0;
    guard = 0;
    while ((busy || full0 || full1) && guard < 1000) begin
      tick();
      guard++;
    end
    chk("rr_drained", busy || full0 || full1, 0);
    chk("rr_frames", lc_q.size(), 7);
    for (int i = 1; i < lc_q.size(); i++) begin
      chk("rr_spacing", lc_q[i] - lc_q[i-1], 162);
    end
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back((i % 2 == 0) ? {1'b0, 8'h40} : {1'b1, 8'h41});
    end
    check_launches("rr");

    // ---- reset in the middle of a frame ----
    req0 = 1'b1; din0 = 8'h99;
    tick();
    req0 = 1'b0;
    tick();
    tick();
    req1 = 1'b1; din1 = 8'hAA;
    tick();
    req1 = 1'b0;
    chk("mid_full1", full1, 1);
    repeat (79) tick();
    chk("mid_busy_before", busy, 1);
    #3;
    reset = 1'b0;
    #1;
    chk("mid_busy", busy, 0);
    chk("mid_txstart", tx_start, 0);
    chk("mid_full0", full0, 0);
    chk("mid_full1_clr", full1, 0);
    chk("mid_rdy0", rdy0, 0);
    chk("mid_rdy1", rdy1, 0);
    chk("mid_txdin", tx_din, 0);
    chk("mid_state", fsm_state, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    chk("mid_rel_rdy0", rdy0, 1);
    chk("mid_rel_rdy1", rdy1, 1);
    base = n_launch;
    repeat (300) tick();
    chk("mid_no_launch", n_launch - base, 0);
    chk("mid_idle", busy, 0);
    exp_q.push_back({1'b0, 8'h99});
    check_launches("mid");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit-side scheduler for the UART peripheral. Two requesters (the processor `UARTwr` path and a second source, e.g. timer/counter event reporting) each own a one-word holding buffer. The block arbitrates between them round-robin, launches `uartTrans` through its `txStart`/`din` interface, and tracks frame progress by counting `sTick` so a new frame never starts before the transmitter is back in idle.

## Interface
Parameters:
- `dataBits`, default 8: data bits per frame; must equal the transmitter's `dataBits`.
- `sbTick`, default 16: stop-bit ticks; must equal the transmitter's `sbTick`.
- `frameTicks` (localparam): `16*(dataBits+1)+sbTick`, which is 160 at the defaults.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-low reset. Low means reset.
- `sTick`, in, 1: baud oversample tick, the same one that drives the transmitter.
- `req0`, in, 1: requester 0 has a valid word.
- `din0`, in, dataBits: requester 0 word.
- `rdy0`, out, 1: buffer 0 can accept a word.
- `req1`, in, 1: requester 1 has a valid word.
- `din1`, in, dataBits: requester 1 word.
- `rdy1`, out, 1: buffer 1 can accept a word.
- `txStart`, out, 1: to the transmitter `txStart`.
- `txDin`, out, dataBits: to the transmitter `din`.
- `txDoneTick`, in, 1: from the transmitter; high marks the cycle `txStart` is accepted.
- `busy`, out, 1: a frame is being launched or is in flight.
- `owner`, out, 1: index of the requester whose word is in flight.
- `full0`, out, 1: buffer 0 occupied.
- `full1`, out, 1: buffer 1 occupied.

## Operation
Buffers:
- `rdyN = !fullN`.
- A transfer happens on the rising edge where `reqN && rdyN`. At that edge `bufN <= dinN` and `fullN <= 1`.
- The requester holds `reqN` and `dinN` until it sees a transfer edge.
- `fullN` clears only on the edge where `txDoneTick` is high in LAUNCH with `owner == N`.
- A requester may refill its buffer while its previous word is still in flight (double buffering).

States: IDLE, LAUNCH, FRAME. `busy = (state != IDLE)`.

IDLE:
- If neither buffer is full, stay in IDLE.
- If exactly one buffer is full, select it.
- If both are full, select `!last`. `last` is the requester served most recently; it resets to 1, so requester 0 wins the first tie.
- On selection, at the same edge: `txDin <= buf[sel]`, `owner <= sel`, go to LAUNCH.

LAUNCH:
- `txStart = 1`. This is a Moore decode of the state.
- Wait for `txDoneTick`, with no timeout.
- On the edge where `txDoneTick` is high: `full[owner] <= 0`, `last <= owner`, `cnt <= 0`, go to FRAME.

FRAME:
- `txStart = 0`.
- On each `sTick`, `cnt <= cnt + 1`.
- When `sTick` is high and `cnt == frameTicks-1`, go to IDLE.
- `cnt` width is `clog2(frameTicks)`. `cnt` never wraps.

`txDin` stability:
- `txDin` changes only on the IDLE-to-LAUNCH edge.
- It is therefore stable through the whole transmitter start state, where `din` is sampled.

Reset (`reset` low), asynchronous, also mid-frame:
- State returns to IDLE.
- `full0 = full1 = 0`, `cnt = 0`, `last = 1`, `owner = 0`, `txDin = 0`.
- `txStart = 0`, `busy = 0`.
- `rdy0 = rdy1 = 0` while `reset` is low; they go to 1 on the first cycle after release.
- Any buffered or in-flight word is discarded.
- The transmitter must be reset in the same event; the integration inverts `reset` for it.

## Timing
- Capture to launch:
  - A word captured at edge E into an otherwise idle block gives LAUNCH after edge E+1.
  - `txStart` is high during the cycle E+1..E+2.
  - The transmitter returns `txDoneTick` in that same cycle, so FRAME is entered at E+2.
- `txStart` is high for exactly one cycle when the transmitter is idle.
- Frame length is `frameTicks` `sTick` pulses after the FRAME entry edge. The IDLE edge coincides with the transmitter's stop-to-idle edge.
- Back-to-back frames: the next `txStart` asserts one cycle after returning to IDLE.
- An `sTick` in the LAUNCH cycle is not counted. The transmitter counts from its own start state, which begins at the same edge.
- `sTick` arriving in IDLE or LAUNCH is ignored.
- Simultaneous events:
  - `reqN` in the same cycle that `fullN` clears: no transfer, because `rdyN` was 0. The transfer happens the next cycle.
  - `req0` and `req1` in the same cycle with both empty: both are captured.
  - Both buffers full in IDLE: arbitration is by `last` only.

## Test plan
- Single word: `req0` with `din0=8'hA5`. Expect:
  - transfer edge, then `txStart` for 1 cycle 2 cycles later with `txDin=8'hA5`;
  - `full0` clears at the `txDoneTick` edge;
  - `busy` high for exactly 160 `sTick` after LAUNCH, then 0;
  - the tx line shows start, 1,0,1,0,0,1,0,1, stop.
- Tie after reset: `req0=8'h11` and `req1=8'h22` in the same cycle. Expect:
  - frame 0x11 with `owner=0`, then 0x22 with `owner=1`;
  - the second `txStart` arrives exactly 1 cycle after `busy` falls.
- Round-robin fairness: both requesters keep their buffers permanently refilled for 6 frames. Expect `owner` to alternate 0,1,0,1,0,1 with no frame overlap.
- Refill during flight: reload `req0=8'h33` while 8'hA5 is in FRAME. Expect:
  - capture within 1 cycle of `full0` clearing;
  - 0x33 launched only after 160 ticks;
  - `txDin` held at 8'hA5 until then.
- Backpressure: `req1` held while `full1=1`. Expect `rdy1=0` and no overwrite; `buf1` keeps its original value until released.
- Reset mid-frame: pull `reset` low at tick 80 of a frame with `full1=1`. Expect immediately `busy=0`, `txStart=0`, `full0=full1=0`, `rdy0=rdy1=0`. After release: `rdy0=rdy1=1`, and no spurious `txStart`.
